// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift unit: op encodings and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational shift of one operand by 0..STEP bits for a given op.
// Rotate support only when SHIFT_UNIT_ROTATE_EN is defined; else ROL acts as SLL.
module shift_step
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int AW    = $clog2(STEP + 1)
) (
    input  shift_op_e        op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AW-1:0]    amt_i,
    output logic [WIDTH-1:0] data_o
);

    logic signed [WIDTH-1:0] sdata;
    assign sdata = data_i;

`ifdef SHIFT_UNIT_ROTATE_EN
    logic [2*WIDTH-1:0] dbl;
    assign dbl = {data_i, data_i} << amt_i;
`endif

    always_comb begin
        data_o = data_i << amt_i;
        case (op_i)
            SHIFT_SRL: data_o = data_i >> amt_i;
            SHIFT_SRA: data_o = sdata >>> amt_i;
`ifdef SHIFT_UNIT_ROTATE_EN
            SHIFT_ROL: data_o = dbl[2*WIDTH-1:WIDTH];
`endif
            default:   data_o = data_i << amt_i;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Iterative shifter: up to STEP bits per cycle, IDLE/SHIFT/DONE handshake.
// Optional rotate via SHIFT_UNIT_ROTATE_EN (see shift_step).
module shift_unit
    import shift_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STEP    = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] sa,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int AW = $clog2(STEP + 1);

    state_e             state_q, state_d;
    shift_op_e          op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] rem_q, rem_d, rem_next;
    logic [AW-1:0]      step_amt;
    logic [WIDTH-1:0]   step_out;

    // Compare one bit wider so STEP == WIDTH is representable.
    assign step_amt = ({1'b0, rem_q} > (SHAMT_W + 1)'(STEP))
                    ? AW'(STEP) : AW'(rem_q);
    assign rem_next = rem_q - SHAMT_W'(step_amt);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .op_i   (op_q),
        .data_i (work_q),
        .amt_i  (step_amt),
        .data_o (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = (sa == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (rem_next == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == ST_IDLE);
        busy  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        done  = (state_q == ST_DONE);
    end

    // Result is written on entry to DONE so it is valid alongside done.
    always_comb begin
        op_d     = op_q;
        work_d   = work_q;
        rem_d    = rem_q;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = shift_op_e'(op);
                    work_d = data_in;
                    rem_d  = sa;
                    if (sa == '0) result_d = data_in;
                end
            end
            ST_SHIFT: begin
                work_d = step_out;
                rem_d  = rem_next;
                if (rem_next == '0) result_d = step_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= SHIFT_SLL;
            work_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit (WIDTH=32, STEP=4).
// Honours SHIFT_UNIT_ROTATE_EN for the expected ROL behaviour.
module tb_shift_unit;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] data_in;
    logic [4:0]   sa;
    logic         ready, busy, done;
    logic [W-1:0] result;

    shift_unit #(.WIDTH(W), .STEP(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .sa      (sa),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_chk = 0;
    int           n_err = 0;
    int           done_cnt = 0;
    logic [W-1:0] last_res = '0;
    logic         prev_done = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o,
                                           input logic [W-1:0] d,
                                           input int s);
`ifdef SHIFT_UNIT_ROTATE_EN
        logic [2*W-1:0] dbl;
`endif
        case (o)
            2'b01: return d >> s;
            2'b10: return $signed(d) >>> s;
`ifdef SHIFT_UNIT_ROTATE_EN
            2'b11: begin
                dbl = {d, d} << s;
                return dbl[2*W-1:W];
            end
`endif
            default: return d << s;
        endcase
    endfunction

    // Monitor: pop on done, and result must hold while an op is in flight.
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("ready_after_done", W'(ready), W'(1));
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("spurious_done", W'(1), W'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", result, mon_e.res);
                    chk("latency", W'(cyc - mon_e.acc + 1), W'(mon_e.lat));
                    last_res = mon_e.res;
                end
            end else if (busy) begin
                chk("hold", result, last_res);
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] d,
                         input int s);
        int   k;
        exp_t e;
        k = 0;
        @(negedge clk);
        while (!ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!ready) begin
            chk("ready_timeout", W'(ready), W'(1));
            return;
        end
        start   = 1'b1;
        op      = o;
        data_in = d;
        sa      = 5'(s);
        @(posedge clk);
        #1;
        e.res = model(o, d, s);
        e.lat = (s + S - 1) / S + 1;
        e.acc = cyc;
        sb.push_back(e);
        start   = 1'b0;
        op      = 2'($urandom);
        data_in = $urandom;
        sa      = 5'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) chk("drain_timeout", W'(sb.size()), W'(0));
        @(negedge clk);
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", W'(ready), W'(1));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_result", result, W'(0));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        data_in = '0;
        sa      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        rst = 1'b0;

        issue(2'b00, 32'h0F0F_F0C3, 4);
        issue(2'b10, 32'h8000_0000, 31);
        issue(2'b01, 32'h8000_0000, 31);
        issue(2'b01, 32'h0F0F_F0C3, 0);
        issue(2'b11, 32'h0F0F_F0C3, 8);
        issue(2'b11, 32'h8000_0001, 1);
        issue(2'b10, 32'h7FFF_FFFF, 5);
        drain();

        for (int i = 0; i < 12; i++) begin
            issue(2'($urandom), $urandom, int'($urandom_range(0, 31)));
        end
        drain();

        // Start pulses while busy must be ignored.
        issue(2'b00, 32'h1234_5678, 31);
        start   = 1'b1;
        data_in = 32'hDEAD_BEEF;
        op      = 2'b01;
        sa      = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Abort in flight: no done may follow the reset.
        issue(2'b00, 32'hA5A5_A5A5, 16);
        start   = 1'b1;
        data_in = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_state();
        sb.delete();
        last_res = '0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        done_cnt = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("no_done_after_rst", W'(done_cnt), W'(0));

        issue(2'b01, 32'hF000_0000, 5);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (power of two, >= 8).
REQ-002 SHALL have parameter STEP, default 4, maximum shift distance applied per cycle (power of two, 1..WIDTH).
REQ-003 SHALL derive localparam SHAMT_W = $clog2(WIDTH).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  request; accepted only when ready=1.
REQ-008 op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-009 data_in  input  WIDTH  operand, sampled on accept.
REQ-010 sa  input  SHAMT_W  shift amount, sampled on accept.
REQ-011 ready  output  1  high only in IDLE.
REQ-012 busy  output  1  high in SHIFT and DONE.
REQ-013 done  output  1  one-cycle pulse, result valid.
REQ-014 result  output  WIDTH  last completed result, registered.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 IDLE: start=1 -> capture op, data_in, sa into working registers; sa==0 -> DONE, else -> SHIFT.
REQ-017 SHIFT: each cycle shift working value by d = min(remaining, STEP), remaining -= d; remaining becomes 0 -> DONE.
REQ-018 DONE: load result from working value, done=1 for exactly this cycle, then -> IDLE.
REQ-019 Latency SHALL be: start accepted at edge T -> done high in cycle T + ceil(sa/STEP) + 1.
REQ-020 SLL/SRL SHALL zero-fill; SRA SHALL replicate bit WIDTH-1 of captured operand.
REQ-021 ROL SHALL rotate left, bits leaving MSB re-entering at LSB.
REQ-022 start while ready=0 SHALL be ignored with no state change (no queuing).
REQ-023 result SHALL hold its value from DONE until the next DONE; it SHALL not change during SHIFT.
REQ-024 data_in, sa, op changes after accept SHALL not affect the operation in flight.
REQ-025 start in the cycle after DONE (IDLE) SHALL be accepted; back-to-back throughput has no extra bubble.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, ready=1, busy=0, done=0, result=0, working registers=0.
REQ-027 rst during SHIFT or DONE SHALL abort the operation; no done pulse SHALL follow.

Configuration
REQ-028 Macro SHIFT_UNIT_ROTATE_EN defined: op=11 performs ROL per REQ-021.
REQ-029 SHIFT_UNIT_ROTATE_EN undefined: op=11 SHALL behave exactly as SLL; no rotate logic compiled.

Structure
REQ-030 Package shift_pkg SHALL hold the op encodings (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL) and the FSM state typedef.
REQ-031 Sub-module shift_step SHALL implement the combinational single-cycle shift by 0..STEP for a given op; shift_unit instantiates it once.

Verification (WIDTH=32, STEP=4)
REQ-032 SLL data_in=0x0F0FF0C3, sa=4 at T -> done at T+2, result=0xF0FF0C30.
REQ-033 SRA data_in=0x80000000, sa=31 at T -> done at T+9, result=0xFFFFFFFF; SRL same inputs -> 0x00000001.
REQ-034 SRL data_in=0x0F0FF0C3, sa=0 at T -> done at T+1, result=0x0F0FF0C3.
REQ-035 op=11, data_in=0x0F0FF0C3, sa=8 -> result=0x0FF0C30F with SHIFT_UNIT_ROTATE_EN, 0x0FF0C300 without.
REQ-036 start SLL sa=16; second start at T+1 with different data ignored; rst pulse at T+3 -> ready=1, result=0, no done through T+10.
